// File: rtl/ifu_lsu_mem_arb.sv
// Shares one memory port between the IFU fetch and LSU load/store channels, one transaction in flight.
// Optional round-robin arbitration via `ARB_ROUND_ROBIN_EN (default: LSU wins simultaneous requests).
module ifu_lsu_mem_arb #(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic            clk,
    input  logic            rst,

    input  logic            ifu_req_valid,
    output logic            ifu_req_ready,
    input  logic [AW-1:0]   ifu_req_addr,
    output logic            ifu_rsp_valid,
    input  logic            ifu_rsp_ready,
    output logic [DW-1:0]   ifu_rsp_rdata,

    input  logic            lsu_req_valid,
    output logic            lsu_req_ready,
    input  logic [AW-1:0]   lsu_req_addr,
    input  logic            lsu_req_wen,
    input  logic [DW-1:0]   lsu_req_wdata,
    input  logic [DW/8-1:0] lsu_req_wmask,
    output logic            lsu_rsp_valid,
    input  logic            lsu_rsp_ready,
    output logic [DW-1:0]   lsu_rsp_rdata,

    output logic            mem_req_valid,
    input  logic            mem_req_ready,
    output logic [AW-1:0]   mem_req_addr,
    output logic            mem_req_wen,
    output logic [DW-1:0]   mem_req_wdata,
    output logic [DW/8-1:0] mem_req_wmask,
    input  logic            mem_rsp_valid,
    output logic            mem_rsp_ready,
    input  logic [DW-1:0]   mem_rsp_rdata
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_IFU = 2'd1,
        WAIT_LSU = 2'd2
    } state_t;

    state_t      state_q;
    state_t      state_d;
    logic        lock_vld;
    logic        lock_own;
    logic        grant_lsu;
    logic        any_vld;
    logic        idle;
    logic        req_hs;
    logic [15:0] ifu_txn_cnt;
    logic [15:0] lsu_txn_cnt;

`ifdef ARB_ROUND_ROBIN_EN
    logic        last_own;
`endif

    assign any_vld = ifu_req_valid | lsu_req_valid;
    assign idle    = (state_q == IDLE);
    assign req_hs  = idle & any_vld & mem_req_ready;

    // grant_lsu: 1 = LSU owns the port, 0 = IFU
    always_comb begin
        grant_lsu = lsu_req_valid;
        if (lock_vld) begin
            grant_lsu = lock_own;
        end else if (ifu_req_valid && lsu_req_valid) begin
`ifdef ARB_ROUND_ROBIN_EN
            grant_lsu = ~last_own;
`else
            grant_lsu = 1'b1;
`endif
        end
    end

    assign ifu_rsp_rdata = mem_rsp_rdata;
    assign lsu_rsp_rdata = mem_rsp_rdata;

    always_comb begin
        state_d       = state_q;
        mem_req_valid = 1'b0;
        mem_req_addr  = '0;
        mem_req_wen   = 1'b0;
        mem_req_wdata = '0;
        mem_req_wmask = '0;
        ifu_req_ready = 1'b0;
        lsu_req_ready = 1'b0;
        mem_rsp_ready = 1'b0;
        ifu_rsp_valid = 1'b0;
        lsu_rsp_valid = 1'b0;
        case (state_q)
            IDLE: begin
                mem_req_valid = any_vld;
                if (grant_lsu && lsu_req_valid) begin
                    mem_req_addr  = lsu_req_addr;
                    mem_req_wen   = lsu_req_wen;
                    mem_req_wdata = lsu_req_wdata;
                    mem_req_wmask = lsu_req_wmask;
                end else if (!grant_lsu && ifu_req_valid) begin
                    mem_req_addr  = ifu_req_addr;
                end
                // Ready is only offered while a request is actually being presented
                ifu_req_ready = any_vld & ~grant_lsu & mem_req_ready;
                lsu_req_ready = any_vld &  grant_lsu & mem_req_ready;
                if (req_hs) begin
                    state_d = grant_lsu ? WAIT_LSU : WAIT_IFU;
                end
            end
            WAIT_IFU: begin
                mem_rsp_ready = ifu_rsp_ready;
                ifu_rsp_valid = mem_rsp_valid;
                if (mem_rsp_valid && ifu_rsp_ready) begin
                    state_d = IDLE;
                end
            end
            WAIT_LSU: begin
                mem_rsp_ready = lsu_rsp_ready;
                lsu_rsp_valid = mem_rsp_valid;
                if (mem_rsp_valid && lsu_rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            lock_vld    <= 1'b0;
            lock_own    <= 1'b0;
            ifu_txn_cnt <= 16'd0;
            lsu_txn_cnt <= 16'd0;
        end else begin
            state_q     <= state_d;
            ifu_txn_cnt <= ifu_txn_cnt + {15'd0, req_hs & ~grant_lsu};
            lsu_txn_cnt <= lsu_txn_cnt + {15'd0, req_hs &  grant_lsu};
            // Freeze the grant while a presented request is stalled by memory
            if (req_hs) begin
                lock_vld <= 1'b0;
            end else if (idle && any_vld && !mem_req_ready) begin
                lock_vld <= 1'b1;
                lock_own <= grant_lsu;
            end
        end
    end

`ifdef ARB_ROUND_ROBIN_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_own <= 1'b1;
        end else if (req_hs) begin
            last_own <= grant_lsu;
        end
    end
`endif

endmodule

// File: tb/tb_ifu_lsu_mem_arb.sv
// Scenario bench for ifu_lsu_mem_arb: a negedge scoreboard checks every memory request and
// every routed response against queued expectations; scenario tasks add inline checks.
module tb_ifu_lsu_mem_arb;

    logic        clk = 1'b0;
    logic        rst;
    logic        ifu_req_valid, ifu_req_ready;
    logic [31:0] ifu_req_addr;
    logic        ifu_rsp_valid, ifu_rsp_ready;
    logic [31:0] ifu_rsp_rdata;
    logic        lsu_req_valid, lsu_req_ready;
    logic [31:0] lsu_req_addr;
    logic        lsu_req_wen;
    logic [31:0] lsu_req_wdata;
    logic [3:0]  lsu_req_wmask;
    logic        lsu_rsp_valid, lsu_rsp_ready;
    logic [31:0] lsu_rsp_rdata;
    logic        mem_req_valid, mem_req_ready;
    logic [31:0] mem_req_addr;
    logic        mem_req_wen;
    logic [31:0] mem_req_wdata;
    logic [3:0]  mem_req_wmask;
    logic        mem_rsp_valid, mem_rsp_ready;
    logic [31:0] mem_rsp_rdata;

    typedef struct packed {
        logic        lsu;
        logic [31:0] addr;
        logic        wen;
        logic [31:0] wdata;
        logic [3:0]  wmask;
    } req_t;

    typedef struct packed {
        logic        lsu;
        logic [31:0] rdata;
    } rsp_t;

    req_t        req_q[$];
    rsp_t        rsp_q[$];
    int          total = 0;
    int          bad   = 0;
    logic [15:0] exp_ifu_cnt = 16'd0;
    logic [15:0] exp_lsu_cnt = 16'd0;

    always #5 clk = ~clk;

    ifu_lsu_mem_arb #(.AW(32), .DW(32)) dut (
        .clk           (clk),
        .rst           (rst),
        .ifu_req_valid (ifu_req_valid),
        .ifu_req_ready (ifu_req_ready),
        .ifu_req_addr  (ifu_req_addr),
        .ifu_rsp_valid (ifu_rsp_valid),
        .ifu_rsp_ready (ifu_rsp_ready),
        .ifu_rsp_rdata (ifu_rsp_rdata),
        .lsu_req_valid (lsu_req_valid),
        .lsu_req_ready (lsu_req_ready),
        .lsu_req_addr  (lsu_req_addr),
        .lsu_req_wen   (lsu_req_wen),
        .lsu_req_wdata (lsu_req_wdata),
        .lsu_req_wmask (lsu_req_wmask),
        .lsu_rsp_valid (lsu_rsp_valid),
        .lsu_rsp_ready (lsu_rsp_ready),
        .lsu_rsp_rdata (lsu_rsp_rdata),
        .mem_req_valid (mem_req_valid),
        .mem_req_ready (mem_req_ready),
        .mem_req_addr  (mem_req_addr),
        .mem_req_wen   (mem_req_wen),
        .mem_req_wdata (mem_req_wdata),
        .mem_req_wmask (mem_req_wmask),
        .mem_rsp_valid (mem_rsp_valid),
        .mem_rsp_ready (mem_rsp_ready),
        .mem_rsp_rdata (mem_rsp_rdata)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: handshakes are sampled on the falling edge before the edge that completes them
    task automatic monitor();
        req_t e;
        rsp_t r;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (mem_req_valid && mem_req_ready) begin
                    total++;
                    if (req_q.size() == 0) begin
                        bad++;
                        $display("FAIL sb_req_unexpected got addr=%h exp=no request", mem_req_addr);
                    end else begin
                        e = req_q.pop_front();
                        if ({mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wmask} !==
                            {e.addr, e.wen, e.wdata, e.wmask}) begin
                            bad++;
                            $display("FAIL sb_req_fields got=%h/%b/%h/%h exp=%h/%b/%h/%h",
                                     mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wmask,
                                     e.addr, e.wen, e.wdata, e.wmask);
                        end
                        total++;
                        if ({ifu_req_ready, lsu_req_ready} !== {~e.lsu, e.lsu}) begin
                            bad++;
                            $display("FAIL sb_req_ready got ifu/lsu=%b%b exp=%b%b",
                                     ifu_req_ready, lsu_req_ready, ~e.lsu, e.lsu);
                        end
                        if (e.lsu) exp_lsu_cnt = exp_lsu_cnt + 16'd1;
                        else       exp_ifu_cnt = exp_ifu_cnt + 16'd1;
                    end
                end
                if (mem_rsp_valid && mem_rsp_ready) begin
                    total++;
                    if (rsp_q.size() == 0) begin
                        bad++;
                        $display("FAIL sb_rsp_unexpected got rdata=%h exp=no response", mem_rsp_rdata);
                    end else begin
                        r = rsp_q.pop_front();
                        if ({ifu_rsp_valid, lsu_rsp_valid} !== {~r.lsu, r.lsu}) begin
                            bad++;
                            $display("FAIL sb_rsp_route got ifu/lsu=%b%b exp=%b%b",
                                     ifu_rsp_valid, lsu_rsp_valid, ~r.lsu, r.lsu);
                        end
                        total++;
                        if ((r.lsu ? lsu_rsp_rdata : ifu_rsp_rdata) !== r.rdata) begin
                            bad++;
                            $display("FAIL sb_rsp_rdata got=%h exp=%h",
                                     r.lsu ? lsu_rsp_rdata : ifu_rsp_rdata, r.rdata);
                        end
                    end
                end
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        ifu_req_valid = 1'b0; ifu_req_addr = 32'h1234; ifu_rsp_ready = 1'b1;
        lsu_req_valid = 1'b0; lsu_req_addr = 32'h5678; lsu_req_wen = 1'b0;
        lsu_req_wdata = 32'h0; lsu_req_wmask = 4'h0; lsu_rsp_ready = 1'b1;
        mem_req_ready = 1'b1; mem_rsp_valid = 1'b0; mem_rsp_rdata = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if ({mem_req_valid, ifu_req_ready, lsu_req_ready, ifu_rsp_valid, lsu_rsp_valid, mem_rsp_ready} !== 6'b0) begin
            bad++;
            $display("FAIL rst_valid_ready got=%b exp=000000",
                     {mem_req_valid, ifu_req_ready, lsu_req_ready, ifu_rsp_valid, lsu_rsp_valid, mem_rsp_ready});
        end
        total++;
        if ({mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wmask} !== 69'd0) begin
            bad++;
            $display("FAIL rst_req_fields got=%h/%b/%h/%h exp=0",
                     mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wmask);
        end
        total++;
        if (dut.state_q !== 2'd0 || dut.lock_vld !== 1'b0) begin
            bad++;
            $display("FAIL rst_state got state=%0d lock=%b exp state=0 lock=0", dut.state_q, dut.lock_vld);
        end
        total++;
        if (dut.ifu_txn_cnt !== 16'd0 || dut.lsu_txn_cnt !== 16'd0) begin
            bad++;
            $display("FAIL rst_counters got=%h/%h exp=0/0", dut.ifu_txn_cnt, dut.lsu_txn_cnt);
        end
        rst = 1'b0;
        ifu_req_addr = 32'h0;
        lsu_req_addr = 32'h0;
        cyc();
    endtask

    task automatic test_simultaneous();
        logic        own;
        logic [31:0] addr;
        ifu_req_addr = 32'h100; lsu_req_addr = 32'h200; lsu_req_wen = 1'b0;
        ifu_req_valid = 1'b1; lsu_req_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
`ifdef ARB_ROUND_ROBIN_EN
            own = (i % 2 == 1);
`else
            own = 1'b1;
`endif
            addr = own ? 32'h200 : 32'h100;
            req_q.push_back('{own, addr, 1'b0, 32'h0, 4'h0});
            #1;
            total++;
            if (mem_req_addr !== addr) begin
                bad++;
                $display("FAIL simul_grant%0d got=%h exp=%h", i, mem_req_addr, addr);
            end
            cyc();
            mem_rsp_valid = 1'b1;
            mem_rsp_rdata = 32'hC0DE0000 + 32'(i);
            rsp_q.push_back('{own, 32'hC0DE0000 + 32'(i)});
            cyc();
            mem_rsp_valid = 1'b0;
        end
        ifu_req_valid = 1'b0; lsu_req_valid = 1'b0;
        #1;
        total++;
        if (dut.ifu_txn_cnt !== exp_ifu_cnt || dut.lsu_txn_cnt !== exp_lsu_cnt) begin
            bad++;
            $display("FAIL simul_counters got=%h/%h exp=%h/%h",
                     dut.ifu_txn_cnt, dut.lsu_txn_cnt, exp_ifu_cnt, exp_lsu_cnt);
        end
        cyc();
    endtask

    task automatic test_single_fetch();
        ifu_req_addr = 32'h80000000; ifu_req_valid = 1'b1; ifu_rsp_ready = 1'b1;
        req_q.push_back('{1'b0, 32'h80000000, 1'b0, 32'h0, 4'h0});
        #1;
        total++;
        if (mem_req_addr !== 32'h80000000 || mem_req_wen !== 1'b0 || mem_req_valid !== 1'b1) begin
            bad++;
            $display("FAIL fetch_req got addr=%h wen=%b vld=%b exp addr=80000000 wen=0 vld=1",
                     mem_req_addr, mem_req_wen, mem_req_valid);
        end
        cyc();
        ifu_req_valid = 1'b0;
        #1;
        total++;
        if (dut.state_q !== 2'd1 || mem_req_valid !== 1'b0) begin
            bad++;
            $display("FAIL fetch_wait got state=%0d vld=%b exp state=1 vld=0", dut.state_q, mem_req_valid);
        end
        mem_rsp_valid = 1'b1; mem_rsp_rdata = 32'h00000013;
        rsp_q.push_back('{1'b0, 32'h00000013});
        #1;
        total++;
        if ({ifu_rsp_valid, lsu_rsp_valid, mem_rsp_ready} !== 3'b101 || ifu_rsp_rdata !== 32'h00000013) begin
            bad++;
            $display("FAIL fetch_rsp got v/v/r=%b rdata=%h exp v/v/r=101 rdata=00000013",
                     {ifu_rsp_valid, lsu_rsp_valid, mem_rsp_ready}, ifu_rsp_rdata);
        end
        cyc();
        mem_rsp_valid = 1'b0;
        #1;
        total++;
        if (dut.state_q !== 2'd0 || dut.ifu_txn_cnt !== exp_ifu_cnt) begin
            bad++;
            $display("FAIL fetch_done got state=%0d cnt=%h exp state=0 cnt=%h",
                     dut.state_q, dut.ifu_txn_cnt, exp_ifu_cnt);
        end
    endtask

    task automatic test_lock();
        ifu_req_addr = 32'h300; ifu_req_valid = 1'b1; mem_req_ready = 1'b0;
        req_q.push_back('{1'b0, 32'h300, 1'b0, 32'h0, 4'h0});
        #1;
        total++;
        if (mem_req_addr !== 32'h300 || ifu_req_ready !== 1'b0) begin
            bad++;
            $display("FAIL lock_c1 got addr=%h rdy=%b exp addr=300 rdy=0", mem_req_addr, ifu_req_ready);
        end
        cyc();
        lsu_req_addr = 32'h400; lsu_req_wen = 1'b0; lsu_req_valid = 1'b1;
        #1;
        total++;
        if (dut.lock_vld !== 1'b1 || mem_req_addr !== 32'h300 || lsu_req_ready !== 1'b0) begin
            bad++;
            $display("FAIL lock_c2 got lock=%b addr=%h lrdy=%b exp lock=1 addr=300 lrdy=0",
                     dut.lock_vld, mem_req_addr, lsu_req_ready);
        end
        cyc();
        #1;
        total++;
        if (mem_req_addr !== 32'h300) begin
            bad++;
            $display("FAIL lock_c3 got addr=%h exp=300", mem_req_addr);
        end
        cyc();
        mem_req_ready = 1'b1;
        req_q.push_back('{1'b1, 32'h400, 1'b0, 32'h0, 4'h0});
        #1;
        total++;
        if (mem_req_addr !== 32'h300 || {ifu_req_ready, lsu_req_ready} !== 2'b10) begin
            bad++;
            $display("FAIL lock_release got addr=%h rdy=%b exp addr=300 rdy=10",
                     mem_req_addr, {ifu_req_ready, lsu_req_ready});
        end
        cyc();
        ifu_req_valid = 1'b0;
        #1;
        total++;
        if (dut.state_q !== 2'd1 || dut.lock_vld !== 1'b0) begin
            bad++;
            $display("FAIL lock_clear got state=%0d lock=%b exp state=1 lock=0", dut.state_q, dut.lock_vld);
        end
        mem_rsp_valid = 1'b1; mem_rsp_rdata = 32'hAAAA0001;
        rsp_q.push_back('{1'b0, 32'hAAAA0001});
        cyc();
        mem_rsp_valid = 1'b0;
        #1;
        total++;
        if (mem_req_addr !== 32'h400 || lsu_req_ready !== 1'b1) begin
            bad++;
            $display("FAIL lock_next got addr=%h lrdy=%b exp addr=400 lrdy=1", mem_req_addr, lsu_req_ready);
        end
        cyc();
        lsu_req_valid = 1'b0;
        mem_rsp_valid = 1'b1; mem_rsp_rdata = 32'hBBBB0002;
        rsp_q.push_back('{1'b1, 32'hBBBB0002});
        cyc();
        mem_rsp_valid = 1'b0;
    endtask

    task automatic test_store();
        lsu_req_addr = 32'h500; lsu_req_wen = 1'b1; lsu_req_wdata = 32'hDEADBEEF;
        lsu_req_wmask = 4'hF; lsu_req_valid = 1'b1;
        req_q.push_back('{1'b1, 32'h500, 1'b1, 32'hDEADBEEF, 4'hF});
        #1;
        total++;
        if ({mem_req_wen, mem_req_wdata, mem_req_wmask} !== {1'b1, 32'hDEADBEEF, 4'hF}) begin
            bad++;
            $display("FAIL store_fields got=%b/%h/%h exp=1/deadbeef/f", mem_req_wen, mem_req_wdata, mem_req_wmask);
        end
        cyc();
        lsu_req_valid = 1'b0; lsu_req_wen = 1'b0; lsu_req_wdata = 32'h0; lsu_req_wmask = 4'h0;
        ifu_req_addr = 32'h600; ifu_req_valid = 1'b1;
        req_q.push_back('{1'b0, 32'h600, 1'b0, 32'h0, 4'h0});
        lsu_rsp_ready = 1'b0;
        mem_rsp_valid = 1'b1; mem_rsp_rdata = 32'h0;
        for (int k = 0; k < 2; k++) begin
            #1;
            total++;
            if ({mem_rsp_ready, ifu_req_ready, lsu_rsp_valid, ifu_rsp_valid} !== 4'b0010) begin
                bad++;
                $display("FAIL store_stall%0d got rr/irdy/lv/iv=%b exp=0010", k,
                         {mem_rsp_ready, ifu_req_ready, lsu_rsp_valid, ifu_rsp_valid});
            end
            cyc();
        end
        lsu_rsp_ready = 1'b1;
        rsp_q.push_back('{1'b1, 32'h0});
        #1;
        total++;
        if (mem_rsp_ready !== 1'b1 || ifu_req_ready !== 1'b0) begin
            bad++;
            $display("FAIL store_rsp got rr=%b irdy=%b exp rr=1 irdy=0", mem_rsp_ready, ifu_req_ready);
        end
        cyc();
        mem_rsp_valid = 1'b0;
        #1;
        total++;
        if (ifu_req_ready !== 1'b1 || dut.lsu_txn_cnt !== exp_lsu_cnt) begin
            bad++;
            $display("FAIL store_after got irdy=%b lcnt=%h exp irdy=1 lcnt=%h",
                     ifu_req_ready, dut.lsu_txn_cnt, exp_lsu_cnt);
        end
        cyc();
        ifu_req_valid = 1'b0;
        mem_rsp_valid = 1'b1; mem_rsp_rdata = 32'h00000093;
        rsp_q.push_back('{1'b0, 32'h00000093});
        cyc();
        mem_rsp_valid = 1'b0;
    endtask

    task automatic test_reset_midop();
        lsu_req_addr = 32'h700; lsu_req_wen = 1'b0; lsu_req_valid = 1'b1;
        req_q.push_back('{1'b1, 32'h700, 1'b0, 32'h0, 4'h0});
        cyc();
        lsu_req_valid = 1'b0;
        #1;
        total++;
        if (dut.state_q !== 2'd2) begin
            bad++;
            $display("FAIL midrst_pre got state=%0d exp=2", dut.state_q);
        end
        mem_rsp_valid = 1'b1; mem_rsp_rdata = 32'h77; lsu_rsp_ready = 1'b1;
        rst = 1'b1;
        #1;
        total++;
        if ({mem_req_valid, ifu_req_ready, lsu_req_ready, ifu_rsp_valid, lsu_rsp_valid, mem_rsp_ready} !== 6'b0) begin
            bad++;
            $display("FAIL midrst_outputs got=%b exp=000000",
                     {mem_req_valid, ifu_req_ready, lsu_req_ready, ifu_rsp_valid, lsu_rsp_valid, mem_rsp_ready});
        end
        total++;
        if (dut.state_q !== 2'd0 || dut.ifu_txn_cnt !== 16'd0 || dut.lsu_txn_cnt !== 16'd0) begin
            bad++;
            $display("FAIL midrst_state got state=%0d cnt=%h/%h exp state=0 cnt=0/0",
                     dut.state_q, dut.ifu_txn_cnt, dut.lsu_txn_cnt);
        end
        exp_ifu_cnt = 16'd0;
        exp_lsu_cnt = 16'd0;
        cyc();
        mem_rsp_valid = 1'b0;
        rst = 1'b0;
        ifu_req_addr = 32'h800; ifu_req_valid = 1'b1;
        req_q.push_back('{1'b0, 32'h800, 1'b0, 32'h0, 4'h0});
        #1;
        total++;
        if (ifu_req_ready !== 1'b1) begin
            bad++;
            $display("FAIL midrst_new got irdy=%b exp=1", ifu_req_ready);
        end
        cyc();
        ifu_req_valid = 1'b0;
        mem_rsp_valid = 1'b1; mem_rsp_rdata = 32'h88;
        rsp_q.push_back('{1'b0, 32'h88});
        cyc();
        mem_rsp_valid = 1'b0;
        #1;
        total++;
        if (dut.ifu_txn_cnt !== 16'd1) begin
            bad++;
            $display("FAIL midrst_cnt got=%h exp=0001", dut.ifu_txn_cnt);
        end
    endtask

    task automatic test_counter_wrap();
        logic [15:0] lsu_before;
        lsu_before = dut.lsu_txn_cnt;
        force dut.ifu_txn_cnt = 16'hFFFC;
        #1;
        release dut.ifu_txn_cnt;
        cyc();
        total++;
        if (dut.ifu_txn_cnt !== 16'hFFFC) begin
            bad++;
            $display("FAIL wrap_preset got=%h exp=fffc", dut.ifu_txn_cnt);
        end
        for (int k = 0; k < 4; k++) begin
            ifu_req_addr = 32'h900 + 32'(4 * k); ifu_req_valid = 1'b1;
            req_q.push_back('{1'b0, 32'h900 + 32'(4 * k), 1'b0, 32'h0, 4'h0});
            cyc();
            ifu_req_valid = 1'b0;
            mem_rsp_valid = 1'b1; mem_rsp_rdata = 32'h9000 + 32'(k);
            rsp_q.push_back('{1'b0, 32'h9000 + 32'(k)});
            cyc();
            mem_rsp_valid = 1'b0;
        end
        #1;
        total++;
        if (dut.ifu_txn_cnt !== 16'h0000) begin
            bad++;
            $display("FAIL wrap_ifu got=%h exp=0000", dut.ifu_txn_cnt);
        end
        total++;
        if (dut.lsu_txn_cnt !== lsu_before) begin
            bad++;
            $display("FAIL wrap_lsu got=%h exp=%h", dut.lsu_txn_cnt, lsu_before);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        fork
            monitor();
        join_none
        test_reset();
        test_simultaneous();
        test_single_fetch();
        test_lock();
        test_store();
        test_reset_midop();
        test_counter_wrap();
        cyc();
        total++;
        if (req_q.size() != 0 || rsp_q.size() != 0) begin
            bad++;
            $display("FAIL sb_drain got req=%0d rsp=%0d exp=0/0", req_q.size(), rsp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ifu_lsu_mem_arb.md
# ifu_lsu_mem_arb

Two-requester arbiter that shares a single instruction/data memory port between the IFU fetch channel and the LSU load/store channel. It sits between the fetch stage and LSU on one side and the memory on the other. It allows at most one outstanding transaction, locks its grant while a request is stalled, and routes each response back to the requester that issued it.

## Interface
Parameters:
- AW, 32, address width (matches `PC_SIZE`)
- DW, 32, data width (matches `XLEN`)

Ports:
- clk  in  1  clock; the block has one clock.
- rst  in  1  reset; asynchronous, active-high.
- ifu_req_valid  in  1  fetch request valid
- ifu_req_ready  out  1  fetch request accepted
- ifu_req_addr  in  AW  fetch address
- ifu_rsp_valid  out  1  fetch response valid
- ifu_rsp_ready  in  1  IFU can take the response
- ifu_rsp_rdata  out  DW  fetched instruction
- lsu_req_valid  in  1  LSU request valid
- lsu_req_ready  out  1  LSU request accepted
- lsu_req_addr  in  AW  LSU address
- lsu_req_wen  in  1  1 = store, 0 = load
- lsu_req_wdata  in  DW  store data
- lsu_req_wmask  in  DW/8  byte-enable mask
- lsu_rsp_valid  out  1  LSU response valid
- lsu_rsp_ready  in  1  LSU can take the response
- lsu_rsp_rdata  out  DW  load data
- mem_req_valid  out  1  memory request valid
- mem_req_ready  in  1  memory accepts the request
- mem_req_addr  out  AW  memory address
- mem_req_wen  out  1  write enable
- mem_req_wdata  out  DW  write data
- mem_req_wmask  out  DW/8  byte enables
- mem_rsp_valid  in  1  memory response valid
- mem_rsp_ready  out  1  arbiter accepts the response
- mem_rsp_rdata  in  DW  response data

## Operation
- FSM states: IDLE, WAIT_IFU, WAIT_LSU. Reset state is IDLE.
- IDLE:
  - mem_req_valid = ifu_req_valid | lsu_req_valid.
  - The mem_req_* fields are muxed from the granted requester.
  - Only the granted requester sees ready: its *_req_ready = mem_req_ready. The other requester's ready = 0.
  - When the request handshakes (mem_req_valid & mem_req_ready), move to WAIT_IFU or WAIT_LSU according to the grant.
- IFU grants drive mem_req_wen = 0, mem_req_wdata = 0 and mem_req_wmask = 0.
- Grant lock:
  - If mem_req_valid = 1 and mem_req_ready = 0, the register lock_vld is set and lock_own holds the grant.
  - While lock_vld = 1, the grant is lock_own, whatever the other requester does.
  - lock_vld clears on the request handshake.
  - The mem_req_* fields stay stable until the handshake.
- WAIT_x:
  - mem_req_valid = 0 and both *_req_ready = 0.
  - mem_rsp_ready = the owner's rsp_ready.
  - The owner's rsp_valid = mem_rsp_valid, and its rdata = mem_rsp_rdata.
  - The non-owner's rsp_valid = 0.
  - On the response handshake, go to IDLE.
- In IDLE, mem_rsp_ready = 0. A spurious mem_rsp_valid is not forwarded.
- A store completes only when its response handshakes (mem_rsp_rdata is don't-care for a store).
- Counters: ifu_txn_cnt and lsu_txn_cnt are internal 16-bit registers.
  - Each increments on the corresponding request handshake and wraps from 0xFFFF to 0.
  - They are visible to the bench hierarchically.
  - Reset value is 0.

## Timing
- Reset values of outputs: all *_valid = 0, all *_ready = 0, and mem_req_addr/wdata/wmask/wen = 0 (no requester valid). rdata outputs are don't-care while their valid is 0.
- Reset values of registers: state = IDLE, lock_vld = 0, last_own = LSU.
- Request path is combinational, with zero added latency from requester to memory.
- Response path is combinational, with zero added latency from memory to owner.
- Minimum period per transaction is 2 cycles: request handshake in cycle N, response handshake no earlier than N+1, next request no earlier than N+2.
- The grant is re-evaluated only in IDLE with lock_vld = 0.
- If rst is asserted mid-transaction, the FSM returns to IDLE asynchronously. An in-flight response is lost, and the counters clear.

## Configuration
- Macro: `ARB_ROUND_ROBIN_EN`.
- Defined (round-robin):
  - When both requesters are valid and unlocked, grant the requester that is not last_own.
  - last_own updates on each request handshake.
  - After reset, simultaneous requests grant the IFU first.
- Undefined (fixed priority):
  - LSU always wins a simultaneous request.
  - The last_own register is not built.

## Test plan
- Single fetch: ifu_req_valid = 1, addr 0x80000000, memory ready. Expect mem_req_addr = 0x80000000 and wen = 0. Then mem_rsp_rdata 0x00000013 appears on ifu_rsp_rdata with ifu_rsp_valid = 1, and lsu_rsp_valid = 0.
- Simultaneous requests, IFU addr 0x100 and LSU addr 0x200, both held for 4 transactions:
  - Fixed priority: every grant is 0x200.
  - `ARB_ROUND_ROBIN_EN`: grants are 0x100, 0x200, 0x100, 0x200.
- Lock: IFU is valid and mem_req_ready = 0 for 3 cycles, and LSU raises valid in cycle 2. Expect mem_req_addr to stay at the IFU address until mem_req_ready = 1, then the IFU response, then the LSU request is granted.
- Store: LSU with wen = 1, wdata 0xDEADBEEF, wmask 0xF. Expect these fields on mem_req_*, and ifu_req_ready = 0 until the LSU response handshakes. With lsu_rsp_ready = 0 for 2 cycles, mem_rsp_ready = 0 for those cycles.
- Reset mid-op: assert rst while in WAIT_LSU. Expect all valid/ready outputs = 0 immediately, the state back in IDLE, and the counters = 0. A new IFU request after reset is then accepted.
- Counter wrap: 65536 IFU transactions. Expect ifu_txn_cnt = 0 and lsu_txn_cnt unchanged.
